dmem_responder: RTL and testbench

Data-memory responder for the RISC-V core's load/store port: the memory end of the access that the datapath initiates with a byte address, lane-replicated write data and a 4-bit byte write mask. It accepts one request at a time through a valid/ready handshake and models a fixed number of wait states. It performs byte-masked writes into an internal word array and returns the full 32-bit word with a single-cycle response pulse. Byte and halfword extraction and sign extension stay in the initiator.

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait states, byte-masked
// word writes and a single-cycle full-word response. Optional alignment check
// is enabled with `define DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    input  logic [1:0]  req_size,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wmask_q;
    logic                  err_q;

    logic [31:0]           mem_q [DEPTH];

    logic                  accept_c;
    logic                  commit_c;
    logic                  req_err_c;
    logic [ADDR_WIDTH-1:0] cm_idx_c;
    logic [31:0]           cm_wdata_c;
    logic [3:0]            cm_wmask_c;
    logic                  cm_err_c;
    logic [31:0]           rd_word_c;
    logic [31:0]           merged_c;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign req_err_c = ((req_size == 2'b01) && req_addr[0])
                     || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                     || (req_size == 2'b11);

    logic unused_c;
    assign unused_c = ^req_addr[31:ADDR_WIDTH+2];
`else
    assign req_err_c = 1'b0;

    logic unused_c;
    assign unused_c = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0], req_size};
`endif

    assign accept_c = (state_q == S_IDLE) && req_valid;

    // With zero wait states the commit happens on the acceptance edge, so the
    // live request fields are used instead of the captured ones.
    assign cm_idx_c   = (state_q == S_IDLE) ? req_addr[ADDR_WIDTH+1:2] : idx_q;
    assign cm_wdata_c = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign cm_wmask_c = (state_q == S_IDLE) ? req_wmask : wmask_q;
    assign cm_err_c   = (state_q == S_IDLE) ? req_err_c : err_q;

    assign rd_word_c = mem_q[cm_idx_c];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merged_c[8*i +: 8] = cm_wmask_c[i] ? cm_wdata_c[8*i +: 8] : rd_word_c[8*i +: 8];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        commit_c    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d = WAIT_INIT;
                    if (WAIT_STATES == 0) begin
                        state_d  = S_RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_RESP;
                    commit_c = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = cm_err_c;
            rsp_rdata_d = cm_err_c ? 32'h0 : merged_c;
        end

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'h0;
            wmask_q     <= 4'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (accept_c) begin
                idx_q   <= req_addr[ADDR_WIDTH+1:2];
                wdata_q <= req_wdata;
                wmask_q <= req_wmask;
                err_q   <= req_err_c;
            end
        end
    end

    // Storage is not reset; reset still blocks a same-edge commit.
    always_ff @(posedge clk) begin
        if (commit_c && !reset && !cm_err_c) begin
            mem_q[cm_idx_c] <= merged_c;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_WIDTH=10, WAIT_STATES=2); honours
// DMEM_MISALIGN_CHECK_EN when defined.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic [1:0]  req_size;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure latency and busy window, return the response.
    task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [1:0] s,
                        output logic [31:0] rd, output logic er);
        int guard;
        int lat;
        int ready_hi;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        req_size  = s;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        req_valid = 1'b0;
        lat = 1;
        ready_hi = 0;
        while (!rsp_valid && lat < 20) begin
            if (req_ready) ready_hi++;
            tick();
            lat++;
        end
        if (req_ready) ready_hi++;
        rd = rsp_rdata;
        er = rsp_err;
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        chk({tag, "_busy"}, 32'(ready_hi), 32'd0);
        tick();
        chk({tag, "_pulse_end"}, {30'h0, rsp_valid, req_ready}, 32'h1);
        chk({tag, "_rdata_hold"}, rsp_rdata, rd);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        int n;
        int gap;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_wmask = 4'h0;
        req_size  = 2'b10;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_err", {31'h0, rsp_err}, 32'h0);

        xfer("wr_word", 32'h10, 32'hDEADBEEF, 4'b1111, 2'b10, rd, er);
        chk("wr_word_rdata", rd, 32'hDEADBEEF);
        chk("wr_word_err", {31'h0, er}, 32'h0);
        xfer("rd_word", 32'h10, 32'h0, 4'b0000, 2'b10, rd, er);
        chk("rd_word_rdata", rd, 32'hDEADBEEF);

        xfer("wr_byte", 32'h12, 32'h55555555, 4'b0100, 2'b00, rd, er);
        chk("wr_byte_rdata", rd, 32'hDE55BEEF);
        xfer("rd_byte", 32'h10, 32'h0, 4'b0000, 2'b10, rd, er);
        chk("rd_byte_rdata", rd, 32'hDE55BEEF);

        xfer("wr_mis", 32'h11, 32'hAAAAAAAA, 4'b0110, 2'b01, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("wr_mis_err", {31'h0, er}, 32'h1);
        chk("wr_mis_rdata", rd, 32'h0);
        xfer("rd_mis", 32'h10, 32'h0, 4'b0000, 2'b10, rd, er);
        chk("rd_mis_rdata", rd, 32'hDE55BEEF);
`else
        chk("wr_mis_err", {31'h0, er}, 32'h0);
        chk("wr_mis_rdata", rd, 32'hDEAAAAEF);
        xfer("rd_mis", 32'h10, 32'h0, 4'b0000, 2'b10, rd, er);
        chk("rd_mis_rdata", rd, 32'hDEAAAAEF);
`endif

        xfer("wr_alias", 32'h1010, 32'h12345678, 4'b1111, 2'b10, rd, er);
        chk("wr_alias_rdata", rd, 32'h12345678);
        xfer("rd_alias", 32'h0010, 32'h0, 4'b0000, 2'b10, rd, er);
        chk("rd_alias_rdata", rd, 32'h12345678);

        // Request A accepted, then B presented and held while busy.
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        req_wmask = 4'b0000;
        req_size  = 2'b10;
        req_valid = 1'b1;
        tick();
        req_addr  = 32'h30;
        req_wdata = 32'hCAFEF00D;
        req_wmask = 4'b1111;
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("busy_a_latency", 32'(n), 32'd3);
        chk("busy_a_rdata", rsp_rdata, 32'h12345678);
        tick();
        gap = 1;
        while (!rsp_valid && gap < 20) begin
            if (!req_ready) req_valid = 1'b0;
            tick();
            gap++;
        end
        req_valid = 1'b0;
        chk("busy_b_gap", 32'(gap), 32'd4);
        chk("busy_b_rdata", rsp_rdata, 32'hCAFEF00D);
        tick();
        xfer("rd_busy_b", 32'h30, 32'h0, 4'b0000, 2'b10, rd, er);
        chk("rd_busy_b_rdata", rd, 32'hCAFEF00D);

        xfer("wr_prior", 32'h20, 32'h01020304, 4'b1111, 2'b10, rd, er);
        chk("wr_prior_rdata", rd, 32'h01020304);

        // Reset asserted asynchronously in the first WAIT cycle of a write.
        req_addr  = 32'h20;
        req_wdata = 32'hFFFFFFFF;
        req_wmask = 4'b1111;
        req_size  = 2'b10;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("mid_pre_ready", {31'h0, req_ready}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_ready", {31'h0, req_ready}, 32'h1);
        chk("mid_valid", {31'h0, rsp_valid}, 32'h0);
        chk("mid_rdata", rsp_rdata, 32'h0);
        chk("mid_err", {31'h0, rsp_err}, 32'h0);
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) n++;
            tick();
        end
        chk("mid_no_pulse", 32'(n), 32'd0);
        xfer("rd_after_rst", 32'h20, 32'h0, 4'b0000, 2'b10, rd, er);
        chk("rd_after_rst_rdata", rd, 32'h01020304);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
